pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers plus PC).
- Generates every stage `load` and `flush` strobe.
- Holds the pipeline frozen across instruction-cache and data-cache misses.
- Inserts load-use bubbles and squashes wrong-path instructions on EX-resolved mispredicts.
- Flushes the reset-less pipeline registers after reset.

Parameters:
INIT_FLUSH_CYCLES, 5, cycles after reset deassertion during which all stages load NOPs/zeroed control words.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
imem_resp  in  1  icache response pulse (fetch data valid)
dmem_resp  in  1  dcache response pulse
mem_read  in  1  MEM-stage control word: load in MEM
mem_write  in  1  MEM-stage control word: store in MEM
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_is_load  in  1  EX instruction is a load
ex_rd  in  5  EX destination register
ex_mispredict  in  1  EX branch/jump outcome differs from prediction
imem_read  out  1  fetch request to icache
dmem_req_en  out  1  qualifies dcache read/write (blocks re-issue after resp)
pc_load  out  1  PC register load
pc_redirect  out  1  PC mux selects EX-corrected target
if_id_load  out  1
if_id_flush  out  1  insert NOP (0x00000013)
id_ex_load  out  1
id_ex_flush  out  1  zero control word
ex_mem_load  out  1
mem_wb_load  out  1

Behaviour:
- States: S_INIT, S_RUN. Sticky bits imem_done, dmem_done.
- Reset (async, rst_n=0):
  - state=S_INIT, init counter=0, sticky bits=0.
  - All outputs 0 except if_id_flush=1 and id_ex_flush=1.
- S_INIT:
  - Outputs: all *_load=1, if_id_flush=1, id_ex_flush=1, pc_load=0, imem_read=0, dmem_req_en=0.
  - After INIT_FLUSH_CYCLES cycles → S_RUN.
- S_RUN, go condition:
  - dmem_pend = mem_read|mem_write.
  - go = (imem_resp|imem_done) & (~dmem_pend | dmem_resp | dmem_done).
- S_RUN, request outputs:
  - imem_read = ~imem_done.
  - dmem_req_en = dmem_pend & ~dmem_done.
- S_RUN, sticky bits:
  - imem_done set on imem_resp when ~go; dmem_done set on dmem_resp when ~go.
  - Both cleared on go.
  - A response arriving in the same cycle as go is consumed, not latched.
- Load-use: lu = ex_is_load & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Stage strobes (all zero-latency combinational from state/inputs):
  - ex_mem_load = mem_wb_load = id_ex_load = go.
  - ~go: every load=0, nothing advances; ex_mispredict stays asserted because ID/EX is frozen.
- go & ex_mispredict (priority over lu):
  - pc_load=1, pc_redirect=1, if_id_load=1, if_id_flush=1, id_ex_flush=1.
- go & lu & ~ex_mispredict:
  - pc_load=0, if_id_load=0, id_ex_flush=1 (one-cycle bubble).
  - Next cycle the load is in MEM, lu drops.
- go otherwise: pc_load=1, if_id_load=1, no flushes.
- Flush strobes are only asserted together with their matching load.
- Simultaneous imem_resp and dmem_resp with dmem_pend: go in that cycle.
- rst_n asserted mid-stall: sticky bits discarded, re-enter S_INIT.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds outputs perf_stall_cycles[31:0] (S_RUN cycles with ~go), perf_bubbles[31:0] (go&lu&~ex_mispredict), perf_flushes[31:0] (go&ex_mispredict).
  - Counters reset to 0 and wrap modulo 2^32.
  - Counters do not count in S_INIT.
- Undefined: ports and counters absent; logic identical otherwise.

Decomposition:
- rv32i_types gains:
  - pipe_ctrl_state_t enum {S_INIT, S_RUN}.
  - Constant NOP_INSTR=32'h00000013, shared with if_id_reg.
- One natural sub-module: hazard_detect (combinational lu computation) instantiated inside pipeline_ctrl.

Test Plan:
1. Reset release, imem_resp held 1: exactly 5 cycles all loads=1 with if_id_flush=id_ex_flush=1, then pc_load=1 every cycle, no flushes.
2. imem_resp low 3 cycles then pulse: all loads 0 for 3 cycles, imem_read=1; pulse cycle all loads=1.
3. mem_read=1, dmem_resp arrives 2 cycles before imem_resp: dmem_done set, dmem_req_en drops to 0; pipeline advances only on the imem_resp cycle; sticky bits clear.
4. ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, go: pc_load=0, if_id_load=0, id_ex_flush=1; with ex_rd=0 there is no bubble.
5. ex_mispredict=1 and lu=1 same go cycle: pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_load=1; mispredict during stall waits until go.
6. rst_n pulsed low while dmem_done=1: outputs go to reset values immediately (async); the next S_INIT sequence is a full 5 cycles.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: pipeline controller state encoding and the NOP
// instruction word also used by the IF/ID register.
package rv32i_types;

  localparam int REG_IDX_W = 5;

  // addi x0, x0, 0 -- canonical NOP loaded into IF/ID on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } pipe_ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the ID instruction reads a register that the
// load currently in EX will write. x0 never causes a hazard.
module hazard_detect
  import rv32i_types::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline. Optional performance
// counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int INIT_FLUSH_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 imem_resp,
  input  logic                 dmem_resp,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mispredict,
  output logic                 imem_read,
  output logic                 dmem_req_en,
  output logic                 pc_load,
  output logic                 pc_redirect,
  output logic                 if_id_load,
  output logic                 if_id_flush,
  output logic                 id_ex_load,
  output logic                 id_ex_flush,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_bubbles,
  output logic [31:0]          perf_flushes,
`endif
  output pipe_ctrl_state_t     dbg_state
);

  localparam int CNT_W = (INIT_FLUSH_CYCLES < 2) ? 1 : $clog2(INIT_FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_FLUSH_CYCLES - 1);

  pipe_ctrl_state_t state;
  logic [CNT_W-1:0] init_cnt;
  logic             imem_done;
  logic             dmem_done;
  logic             dmem_pend;
  logic             run;
  logic             go;
  logic             lu;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .load_use    (lu)
  );

  // A response that coincides with go is consumed by that advance, so the
  // sticky bits only capture responses that arrive while still stalled.
  always_comb begin
    dmem_pend = mem_read || mem_write;
    run       = (state == S_RUN);
    go        = run && (imem_resp || imem_done) &&
                (!dmem_pend || dmem_resp || dmem_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      imem_done <= 1'b0;
      dmem_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt == INIT_LAST) state <= S_RUN;
          else init_cnt <= init_cnt + 1'b1;
        end
        S_RUN: begin
          if (go) begin
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
          end else begin
            if (imem_resp) imem_done <= 1'b1;
            if (dmem_resp) dmem_done <= 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    imem_read   = 1'b0;
    dmem_req_en = 1'b0;
    pc_load     = 1'b0;
    pc_redirect = 1'b0;
    if_id_load  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_load  = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_load = 1'b0;
    mem_wb_load = 1'b0;
    if (!rst_n) begin
      // Flushes held high while in reset so the reset-less registers see NOPs.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!run) begin
      if_id_load  = 1'b1;
      if_id_flush = 1'b1;
      id_ex_load  = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
    end else begin
      imem_read   = !imem_done;
      dmem_req_en = dmem_pend && !dmem_done;
      id_ex_load  = go;
      ex_mem_load = go;
      mem_wb_load = go;
      if (go && ex_mispredict) begin
        pc_load     = 1'b1;
        pc_redirect = 1'b1;
        if_id_load  = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (go && lu) begin
        id_ex_flush = 1'b1;
      end else if (go) begin
        pc_load    = 1'b1;
        if_id_load = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_flushes      <= '0;
    end else if (run) begin
      if (!go) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (go && lu && !ex_mispredict) perf_bubbles <= perf_bubbles + 32'd1;
      if (go && ex_mispredict) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

  assign dbg_state = state;

endmodule
